// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Program sequencer that sits above the CU. It fetches 16-bit instruction
//   words from ROM, decodes them onto the CU's opcode/dest/src inputs, waits
//   for the CU to report completion (cu_state == 3'b111), returns the CU to
//   its idle state by dropping opcode to zero, and then advances the PC.
//
//   Instruction word: [15:12] opcode, [11:6] dest, [5:0] src/immediate.
//     4'hF         HLT     stop; pc left on the HLT word, not counted
//     4'h0         NOP     skipped without involving the CU
//     4'hD, 4'hE   illegal flagged (sticky), then skipped like a NOP
//     4'h1..4'hC   CU op   handed to the CU until it reports done
//
// Parameters
//   START_ADDR  PC loaded on reset and on every start
//   TIMEOUT     max EXEC cycles before the CU is declared hung (2..255)
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   asynchronous active-high reset
//   start            in   1-cycle pulse, honoured only when idle or halted
//   cu_state[2:0]    in   CU progress, 3'b111 = instruction complete
//   rom_data[15:0]   in   ROM word, valid the cycle after rom_read_enable
//   rom_read_enable  out  ROM read strobe
//   rom_address[7:0] out  ROM address (always equals pc)
//   opcode[3:0]      out  CU opcode, zero outside EXEC
//   dest[5:0]        out  CU destination field, zero outside EXEC
//   src[5:0]         out  CU source / immediate field, zero outside EXEC
//   pc[7:0]          out  program counter
//   busy             out  high in FETCH/LATCH/EXEC/CLEAR
//   halted           out  high in HALTED
//   instr_count[15:0]out  retired instructions since start, saturating
//   err_illegal      out  sticky: illegal opcode fetched
//   err_timeout      out  sticky: CU failed to finish within TIMEOUT cycles
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter int         TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  cu_state,
  input  logic [15:0] rom_data,
  output logic        rom_read_enable,
  output logic [7:0]  rom_address,
  output logic [3:0]  opcode,
  output logic [5:0]  dest,
  output logic [5:0]  src,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic [15:0] instr_count,
  output logic        err_illegal,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_CLEAR  = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_IL1  = 4'hD;
  localparam logic [3:0] OP_IL2  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam logic [2:0] CU_DONE = 3'b111;

  // Last legal value of the EXEC cycle counter; reaching it without done
  // means the CU has been given TIMEOUT cycles and is declared hung.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [15:0] ir_reg, ir_next;
  logic [15:0] count_reg, count_next;
  logic [7:0]  tmo_reg, tmo_next;
  logic        halt_pend_reg, halt_pend_next;
  logic        err_ill_reg, err_ill_next;
  logic        err_tmo_reg, err_tmo_next;

  logic [15:0] count_inc;
  logic [7:0]  pc_inc;
  logic [3:0]  fetched_op;

  assign count_inc  = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
  assign pc_inc     = pc_reg + 8'd1;   // natural 8-bit wrap FF -> 00
  assign fetched_op = rom_data[15:12];

  // ---------------------------------------------------------------------------
  // Next-state and datapath decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    count_next     = count_reg;
    tmo_next       = tmo_reg;
    halt_pend_next = halt_pend_reg;
    err_ill_next   = err_ill_reg;
    err_tmo_next   = err_tmo_reg;

    case (state_reg)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_next     = S_FETCH;
          pc_next        = START_ADDR;
          count_next     = 16'd0;
          halt_pend_next = 1'b0;
          err_ill_next   = 1'b0;
          err_tmo_next   = 1'b0;
        end
      end

      S_FETCH: begin
        state_next = S_LATCH;
      end

      S_LATCH: begin
        // Decode directly on the ROM word so EXEC can start next cycle.
        ir_next = rom_data;
        case (fetched_op)
          OP_HLT: begin
            state_next = S_HALTED;
          end
          OP_NOP, OP_IL1, OP_IL2: begin
            if (fetched_op != OP_NOP) begin
              err_ill_next = 1'b1;
            end
            pc_next    = pc_inc;
            count_next = count_inc;
            state_next = S_FETCH;
          end
          default: begin
            tmo_next   = 8'd0;
            state_next = S_EXEC;
          end
        endcase
      end

      S_EXEC: begin
        tmo_next = tmo_reg + 8'd1;
        // done wins over timeout when both happen on the last allowed cycle
        if (cu_state == CU_DONE) begin
          state_next = S_CLEAR;
        end else if (tmo_reg == TMO_LAST) begin
          err_tmo_next   = 1'b1;
          halt_pend_next = 1'b1;
          state_next     = S_CLEAR;
        end
      end

      S_CLEAR: begin
        // opcode is zero in this cycle, which forces the CU back to 000.
        if (halt_pend_reg) begin
          state_next = S_HALTED;
        end else begin
          pc_next    = pc_inc;
          count_next = count_inc;
          state_next = S_FETCH;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Outputs are decoded from the next state so
  // they line up with the state they describe without a combinational path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      pc_reg          <= START_ADDR;
      ir_reg          <= 16'd0;
      count_reg       <= 16'd0;
      tmo_reg         <= 8'd0;
      halt_pend_reg   <= 1'b0;
      err_ill_reg     <= 1'b0;
      err_tmo_reg     <= 1'b0;
      rom_read_enable <= 1'b0;
      opcode          <= 4'd0;
      dest            <= 6'd0;
      src             <= 6'd0;
      busy            <= 1'b0;
      halted          <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      ir_reg          <= ir_next;
      count_reg       <= count_next;
      tmo_reg         <= tmo_next;
      halt_pend_reg   <= halt_pend_next;
      err_ill_reg     <= err_ill_next;
      err_tmo_reg     <= err_tmo_next;
      rom_read_enable <= (state_next == S_FETCH);
      if (state_next == S_EXEC) begin
        opcode <= ir_next[15:12];
        dest   <= ir_next[11:6];
        src    <= ir_next[5:0];
      end else begin
        opcode <= 4'd0;
        dest   <= 6'd0;
        src    <= 6'd0;
      end
      busy   <= (state_next == S_FETCH) || (state_next == S_LATCH) ||
                (state_next == S_EXEC)  || (state_next == S_CLEAR);
      halted <= (state_next == S_HALTED);
    end
  end

  assign rom_address = pc_reg;
  assign pc          = pc_reg;
  assign instr_count = count_reg;
  assign err_illegal = err_ill_reg;
  assign err_timeout = err_tmo_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//   Drives instr_sequencer with a ROM model and a small CU model whose
//   completion latency is programmable per ROM address (0 = never finishes).
//   Each program run is compared against a transaction-level reference that
//   walks the ROM image and predicts pc, count, error flags, cycle count and
//   the list of instructions handed to the CU.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cu_state = 3'b000;
  logic [15:0] rom_data = 16'h0000;
  logic        rom_read_enable;
  logic [7:0]  rom_address;
  logic [3:0]  opcode;
  logic [5:0]  dest;
  logic [5:0]  src;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] instr_count;
  logic        err_illegal;
  logic        err_timeout;

  instr_sequencer #(.START_ADDR(8'h00), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .cu_state(cu_state),
    .rom_data(rom_data), .rom_read_enable(rom_read_enable),
    .rom_address(rom_address), .opcode(opcode), .dest(dest), .src(src),
    .pc(pc), .busy(busy), .halted(halted), .instr_count(instr_count),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  int          lat_tab [256];
  logic [7:0]  regs [64];
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          viol = 0;
  int          k = 0;

  // ROM: registered read, data valid the cycle after the strobe
  always @(posedge clk) begin
    if (rom_read_enable) rom_data <= rom[rom_address];
  end

  // CU model: reports done after lat_tab[pc] cycles of a non-zero opcode
  always @(negedge clk) begin
    if (rst) begin
      k        <= 0;
      cu_state <= 3'b000;
    end else begin
      if (cu_state == 3'b111 && opcode != 4'h0) viol <= viol + 1;
      if (opcode == 4'h0) begin
        k        <= 0;
        cu_state <= 3'b000;
      end else begin
        if (k == 0) obs_q.push_back({opcode, dest, src});
        if (lat_tab[rom_address] != 0 && k + 1 >= lat_tab[rom_address]) begin
          if (k + 1 == lat_tab[rom_address]) begin
            case (opcode)
              4'hC:    regs[dest] <= {2'b00, src};
              4'h2:    regs[dest] <= regs[dest] + regs[src];
              default: ;
            endcase
          end
          cu_state <= 3'b111;
        end else begin
          cu_state <= 3'(k % 6 + 1);
        end
        k <= k + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {11'd0, rom_read_enable, rom_address, opcode, dest, src, pc,
            busy, halted, instr_count, err_illegal, err_timeout};
  endfunction

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 256; i++) begin
      rom[i]     = w;
      lat_tab[i] = 1;
    end
  endtask

  // Transaction-level reference: walk the ROM image instruction by instruction
  task automatic model(output logic [7:0] e_pc, output logic [15:0] e_cnt,
                       output logic e_ill, output logic e_tmo, output int e_cyc);
    int p;
    int cnt;
    logic [15:0] w;
    logic [3:0]  op;
    p = 0; cnt = 0; e_ill = 1'b0; e_tmo = 1'b0; e_cyc = 0;
    exp_q.delete();
    for (int step = 0; step < 2000; step++) begin
      w = rom[p];
      op = w[15:12];
      e_cyc += 2;
      if (op == 4'hF) break;
      if (op == 4'h0 || op == 4'hD || op == 4'hE) begin
        if (op != 4'h0) e_ill = 1'b1;
        p = (p + 1) % 256;
        if (cnt < 65535) cnt++;
        continue;
      end
      exp_q.push_back(w);
      if (lat_tab[p] == 0 || lat_tab[p] > TIMEOUT) begin
        e_tmo = 1'b1;
        e_cyc += TIMEOUT + 1;
        break;
      end
      e_cyc += lat_tab[p] + 1;
      p = (p + 1) % 256;
      if (cnt < 65535) cnt++;
    end
    e_pc  = 8'(p);
    e_cnt = 16'(cnt);
  endtask

  // Pulse start and count rising edges until halted (bounded)
  task automatic run(input bit pulse_busy, input bit wrap, output int n);
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (halted) break;
      if (wrap && pc == 8'hF0) rom[2] = 16'hF000;
      if (pulse_busy && (n % 37 == 0)) start = 1'b1;
    end
    start = 1'b0;
    check("halt_reached", halted, 1);
  endtask

  task automatic verify(input string name, input int n);
    logic [7:0]  e_pc;
    logic [15:0] e_cnt;
    logic        e_ill, e_tmo;
    int          e_cyc;
    int          m;
    model(e_pc, e_cnt, e_ill, e_tmo, e_cyc);
    check("cycles", n, 1 + e_cyc);
    check("pc", pc, e_pc);
    check("count", instr_count, e_cnt);
    check("err_illegal", err_illegal, e_ill);
    check("err_timeout", err_timeout, e_tmo);
    check("busy_end", busy, 0);
    check("opcode_end", opcode, 0);
    check("n_issue", obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check("issue", obs_q[i], exp_q[i]);
    $display("run %s: cycles=%0d pc=%02h count=%0d ill=%0b tmo=%0b issued=%0d",
             name, n, pc, instr_count, err_illegal, err_timeout, obs_q.size());
  endtask

  initial begin
    int n;
    int reads;
    int len;
    int kind;
    logic [3:0] op;

    for (int i = 0; i < 64; i++) regs[i] = 8'd0;
    fill_rom(16'hF000);

    // 1: reset and idle quiet
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    reads = 0;
    repeat (6) begin
      @(negedge clk);
      if (rom_read_enable) reads++;
    end
    check("idle_reads", reads, 0);
    check("idle_outs", all_outs(), 64'd0);
    $display("reset: outputs quiet, reads=%0d", reads);

    // 2: MVI r1,#5 ; MVI r2,#3 ; ADD r1,r2 ; HLT
    fill_rom(16'hF000);
    rom[0] = 16'hC045; lat_tab[0] = 1;
    rom[1] = 16'hC083; lat_tab[1] = 1;
    rom[2] = 16'h2042; lat_tab[2] = 4;
    run(0, 0, n);
    verify("program", n);
    check("ram1", regs[1], 8);
    check("prog_pc", pc, 8'h03);
    check("prog_count", instr_count, 3);

    // 3: NOP, illegal, HLT
    fill_rom(16'hF000);
    rom[0] = 16'h0000;
    rom[1] = 16'hD000;
    run(0, 0, n);
    verify("nop_illegal", n);
    check("no_cu_op", obs_q.size(), 0);

    // 4: CU stuck -> timeout
    fill_rom(16'hF000);
    rom[0] = 16'h1041; lat_tab[0] = 0;
    run(0, 0, n);
    verify("timeout", n);
    check("tmo_pc", pc, 8'h00);

    // 5: all NOP, pc wraps, HLT planted at 02 after the wrap; busy starts ignored
    fill_rom(16'h0000);
    run(1, 1, n);
    check("wrap_cycles", n, 519);
    check("wrap_pc", pc, 8'h02);
    check("wrap_count", instr_count, 258);
    check("wrap_errs", {err_illegal, err_timeout}, 0);
    $display("run wrap: cycles=%0d pc=%02h count=%0d", n, pc, instr_count);

    // 6: reset during MUL, then rerun
    fill_rom(16'hF000);
    rom[0] = 16'h5042; lat_tab[0] = 5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (opcode == 4'h5) break;
      @(negedge clk);
    end
    check("mul_seen", opcode, 4'h5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midrun_reset_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 0, n);
    verify("after_reset", n);
    $display("midrun reset: outputs cleared, rerun count=%0d", instr_count);

    // Randomized programs
    for (int r = 0; r < 12; r++) begin
      fill_rom(16'hF000);
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          rom[i] = {4'h0, 12'($urandom)};
        end else if (kind == 1) begin
          op = 4'($urandom_range(13, 14));
          rom[i] = {op, 12'($urandom)};
        end else begin
          op = 4'($urandom_range(1, 12));
          rom[i] = {op, 12'($urandom)};
          case ($urandom_range(0, 19))
            0:       lat_tab[i] = TIMEOUT;
            1:       lat_tab[i] = TIMEOUT + 1;
            2:       lat_tab[i] = 0;
            default: lat_tab[i] = $urandom_range(1, 6);
          endcase
        end
      end
      rom[len] = {4'hF, 12'($urandom)};
      run(0, 0, n);
      verify($sformatf("random%0d", r), n);
    end

    check("op_after_done", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
